// File: rtl/act_stage_pkg.sv
// Shared definitions for the activation stage: FSM state encoding and Q16.16 constants.
// EVAL2 exists only when ACT_SIGMOID_EN is defined.
package act_stage_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVAL  = 2'd1,
`ifdef ACT_SIGMOID_EN
    EVAL2 = 2'd2,
`endif
    PUSH  = 2'd3
  } act_state_t;

  localparam logic [31:0] Q_FIVE     = 32'h0005_0000;
  localparam logic [31:0] Q_2P375    = 32'h0002_6000;
  localparam logic [31:0] Q_ONE      = 32'h0001_0000;
  localparam logic [31:0] Q_0P84375  = 32'h0000_D800;
  localparam logic [31:0] Q_0P625    = 32'h0000_A000;
  localparam logic [31:0] Q_HALF     = 32'h0000_8000;

endpackage

// File: rtl/act_fifo.sv
// Synchronous FIFO with modulo-depth pointers; a write while full is accepted
// when a read frees the slot in the same cycle.
module act_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_wr, do_rd;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign rd_data = mem[rd_ptr];
  assign do_rd   = rd_en & ~empty;
  assign do_wr   = wr_en & (~full | do_rd);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
      end
      if (do_rd) rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/act_stage.sv
// Activation stage: captures final sums, applies ReLU (or PLAN sigmoid when
// ACT_SIGMOID_EN is defined) and buffers results behind a valid/ack handshake.
module act_stage
  import act_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FRAC_BITS  = 16,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] ac_out,
  input  logic                  ac_rdy,
  input  logic                  off,
  output logic [DATA_WIDTH-1:0] act_out,
  output logic                  act_vld,
  input  logic                  act_ack,
  output logic                  act_busy,
  output logic                  err_ovf,
  input  logic                  err_clr
);

  // Fixed-point constants live in act_stage_pkg as Q16.16; FRAC_BITS is interface-only.
  localparam int unsigned frac_bits_unused = FRAC_BITS;

  act_state_t            state, state_nxt;
  logic                  pend_full, pend_full_nxt;
  logic [DATA_WIDTH-1:0] pend_data, work, result;
  logic                  capture, take, drop, push, pop;
  logic                  fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count_unused;

`ifdef ACT_SIGMOID_EN
  localparam logic [DATA_WIDTH-1:0] MAG_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  logic [DATA_WIDTH-1:0] mag, mag_r, sig_y;
  logic                  neg_r, ge_five, ge_mid, ge_one;

  always_comb begin
    if (!work[DATA_WIDTH-1])              mag = work;
    else if (work[DATA_WIDTH-2:0] == '0)  mag = MAG_MAX;
    else                                  mag = ~work + 1'b1;
    if (ge_five)     sig_y = DATA_WIDTH'(Q_ONE);
    else if (ge_mid) sig_y = (mag_r >> 5) + DATA_WIDTH'(Q_0P84375);
    else if (ge_one) sig_y = (mag_r >> 3) + DATA_WIDTH'(Q_0P625);
    else             sig_y = (mag_r >> 2) + DATA_WIDTH'(Q_HALF);
  end
`endif

  always_comb begin
    capture       = ac_rdy & off;
    take          = (state == IDLE) & pend_full;
    drop          = capture & pend_full & ~take;
    pop           = ~fifo_empty & act_ack;
    push          = (state == PUSH) & (~fifo_full | pop);
    pend_full_nxt = capture | (pend_full & ~take);
    state_nxt     = state;
    case (state)
      IDLE:  if (pend_full) state_nxt = EVAL;
`ifdef ACT_SIGMOID_EN
      EVAL:  state_nxt = EVAL2;
      EVAL2: state_nxt = PUSH;
`else
      EVAL:  state_nxt = PUSH;
`endif
      PUSH:  if (push) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pend_full <= 1'b0;
      pend_data <= '0;
      work      <= '0;
      result    <= '0;
      act_busy  <= 1'b0;
      err_ovf   <= 1'b0;
`ifdef ACT_SIGMOID_EN
      mag_r     <= '0;
      neg_r     <= 1'b0;
      ge_five   <= 1'b0;
      ge_mid    <= 1'b0;
      ge_one    <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      pend_full <= pend_full_nxt;
      act_busy  <= pend_full_nxt | (state_nxt != IDLE);
      if (capture && !drop) pend_data <= ac_out;
      if (take) work <= pend_data;
      if (drop)         err_ovf <= 1'b1;
      else if (err_clr) err_ovf <= 1'b0;
      if (state == EVAL) begin
`ifdef ACT_SIGMOID_EN
        mag_r   <= mag;
        neg_r   <= work[DATA_WIDTH-1];
        ge_five <= (mag >= DATA_WIDTH'(Q_FIVE));
        ge_mid  <= (mag >= DATA_WIDTH'(Q_2P375));
        ge_one  <= (mag >= DATA_WIDTH'(Q_ONE));
`else
        result  <= work[DATA_WIDTH-1] ? '0 : work;
`endif
      end
`ifdef ACT_SIGMOID_EN
      if (state == EVAL2) result <= neg_r ? DATA_WIDTH'(Q_ONE) - sig_y : sig_y;
`endif
    end
  end

  act_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push),
    .wr_data (result),
    .rd_en   (pop),
    .rd_data (act_out),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count_unused)
  );

  assign act_vld = ~fifo_empty;

endmodule

// File: tb/tb_act_stage.sv
// Self-checking bench for act_stage against a transaction-level reference model.
module tb_act_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ac_out;
  logic        ac_rdy, off, act_ack, err_clr;
  logic [31:0] act_out;
  logic        act_vld, act_busy, err_ovf;

  int n_cmp = 0;
  int n_err = 0;

`ifdef ACT_SIGMOID_EN
  localparam int EVAL_CYCLES = 2;
  localparam int LAT_EXP     = 4;
`else
  localparam int EVAL_CYCLES = 1;
  localparam int LAT_EXP     = 3;
`endif

  act_stage #(
    .DATA_WIDTH (32),
    .FRAC_BITS  (16),
    .FIFO_DEPTH (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ac_out   (ac_out),
    .ac_rdy   (ac_rdy),
    .off      (off),
    .act_out  (act_out),
    .act_vld  (act_vld),
    .act_ack  (act_ack),
    .act_busy (act_busy),
    .err_ovf  (err_ovf),
    .err_clr  (err_clr)
  );

  always #5 clk = ~clk;

  // Reference model: one pending slot, an engine that needs a fixed number of
  // cycles per result, and a two-entry output queue.
  bit          m_pend_full;
  logic [31:0] m_pend_val;
  bit          m_eng_busy;
  int          m_eng_cnt;
  logic [31:0] m_eng_val;
  logic [31:0] m_q[$];
  bit          m_err;

  function automatic logic [31:0] ref_act(input logic [31:0] x);
    longint v, a, y;
    v = longint'(signed'(x));
`ifdef ACT_SIGMOID_EN
    a = (v < 0) ? -v : v;
    if (a > 64'h7FFF_FFFF) a = 64'h7FFF_FFFF;
    if (a >= 5 * 65536)        y = 65536;
    else if (a >= 155648)      y = a / 32 + 55296;
    else if (a >= 65536)       y = a / 8 + 40960;
    else                       y = a / 4 + 32768;
    if (v < 0) y = 65536 - y;
    return y[31:0];
`else
    a = 0;
    y = (v < 0) ? a : v;
    return y[31:0];
`endif
  endfunction

  task automatic model_clear();
    m_pend_full = 0;
    m_pend_val  = '0;
    m_eng_busy  = 0;
    m_eng_cnt   = 0;
    m_eng_val   = '0;
    m_q.delete();
    m_err       = 0;
  endtask

  task automatic model_edge(input logic rdy, input logic o, input logic [31:0] v,
                            input logic ack, input logic clr);
    bit pop, push, take, cap, drop;
    logic [31:0] old_pend, old_eng;
    old_pend = m_pend_val;
    old_eng  = m_eng_val;
    pop  = (m_q.size() > 0) && ack;
    push = m_eng_busy && (m_eng_cnt == 0) && ((m_q.size() < 2) || pop);
    take = !m_eng_busy && m_pend_full;
    cap  = rdy && o;
    drop = cap && m_pend_full && !take;
    if (cap && !drop) begin
      m_pend_full = 1;
      m_pend_val  = v;
    end else if (take) begin
      m_pend_full = 0;
    end
    if (take) begin
      m_eng_busy = 1;
      m_eng_cnt  = EVAL_CYCLES;
      m_eng_val  = ref_act(old_pend);
    end else if (m_eng_busy) begin
      if (m_eng_cnt > 0) m_eng_cnt--;
      else if (push)     m_eng_busy = 0;
    end
    if (pop)  void'(m_q.pop_front());
    if (push) m_q.push_back(old_eng);
    if (drop)     m_err = 1;
    else if (clr) m_err = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("act_vld", {31'b0, act_vld}, {31'b0, m_q.size() > 0});
    if (m_q.size() > 0) check("act_out", act_out, m_q[0]);
    check("act_busy", {31'b0, act_busy}, {31'b0, m_pend_full || m_eng_busy});
    check("err_ovf", {31'b0, err_ovf}, {31'b0, m_err});
  endtask

  task automatic step(input logic rdy, input logic o, input logic [31:0] v,
                      input logic ack, input logic clr);
    ac_rdy = rdy; off = o; ac_out = v; act_ack = ack; err_clr = clr;
    @(posedge clk);
    model_edge(rdy, o, v, ack, clr);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #3;
    model_clear();
    check("rst_out",  act_out, 32'h0);
    check("rst_vld",  {31'b0, act_vld}, 32'h0);
    check("rst_busy", {31'b0, act_busy}, 32'h0);
    check("rst_err",  {31'b0, err_ovf}, 32'h0);
    reset = 1'b0;
  endtask

  task automatic run_one(input logic [31:0] x, input logic [31:0] exp);
    int lat;
    step(1, 1, x, 0, 0);
    lat = 0;
    while (!act_vld && lat < 10) begin
      step(0, 0, '0, 0, 0);
      lat++;
    end
    check("latency", lat, LAT_EXP);
    check("result", act_out, exp);
    step(0, 0, '0, 1, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_drain;
    logic [31:0] v;
    reset = 1'b1; ac_out = '0; ac_rdy = 0; off = 0; act_ack = 0; err_clr = 0;
    model_clear();
    @(posedge clk);
    #1;
    do_reset();

    // Partial sums and off without ac_rdy are ignored.
    for (int i = 0; i < 4; i++) step(1, 0, 32'h0003_0000, 0, 0);
    for (int i = 0; i < 2; i++) step(0, 1, 32'h0003_0000, 0, 0);
    check("partial_vld",  {31'b0, act_vld}, 32'h0);
    check("partial_busy", {31'b0, act_busy}, 32'h0);

`ifdef ACT_SIGMOID_EN
    run_one(32'h0000_0000, 32'h0000_8000);
    run_one(32'h0001_0000, 32'h0000_C000);
    run_one(32'hFFFF_0000, 32'h0000_4000);
    run_one(32'h0006_0000, 32'h0001_0000);
    run_one(32'h8000_0000, 32'h0000_0000);
`else
    run_one(32'hFFFE_0000, 32'h0000_0000);
    run_one(32'h0001_8000, 32'h0001_8000);
`endif

    // Stall downstream with a final sum every cycle.
    for (int i = 0; i < 12; i++) step(1, 1, 32'h0001_0000 + 32'(i) * 32'h100, 0, 0);
    check("ovf_set", {31'b0, err_ovf}, 32'h1);
    step(1, 1, 32'h0004_0000, 0, 1);
    check("clr_with_drop", {31'b0, err_ovf}, 32'h1);
    step(0, 0, '0, 0, 1);
    check("clr_alone", {31'b0, err_ovf}, 32'h0);
    n_drain = 0;
    for (int i = 0; i < 20; i++) begin
      if (act_vld) n_drain++;
      step(0, 0, '0, 1, 0);
    end
    check("drain_count", n_drain, 4);

    // Reset while EVAL is in progress and one result is buffered.
    step(1, 1, 32'h0002_0000, 0, 0);
    for (int i = 0; i < 10 && !act_vld; i++) step(0, 0, '0, 0, 0);
    check("pre_rst_vld", {31'b0, act_vld}, 32'h1);
    step(1, 1, 32'h0003_0000, 0, 0);
    step(0, 0, '0, 0, 0);
    do_reset();
    for (int i = 0; i < 8; i++) step(0, 0, '0, 1, 0);
    check("no_stale", {31'b0, act_vld}, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 7))
        0: v = 32'h8000_0000;
        1: v = 32'h7FFF_FFFF;
        2: v = $urandom_range(0, 32'h000C_0000);
        3: v = -$urandom_range(0, 32'h000C_0000);
        default: v = $urandom;
      endcase
      if ($urandom_range(0, 499) == 0) begin
        #1;
        do_reset();
      end
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, v,
           $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
